// File: rtl/ascon_serial_ctrl.sv
// Serial sequencer for the three-share Ascon decryption core: shifts host data in MSB first, runs the core, collects plaintext/tag LSB first.
// Optional WAIT watchdog with err output: define ASCON_CTRL_TIMEOUT_EN.
module ascon_serial_ctrl #(
  parameter int K         = 128,
  parameter int L         = 40,
  parameter int Y         = 80,
  parameter int START_CYC = 3,
  parameter int DRAIN_CYC = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [K-1:0]   key,
  input  logic [127:0]   nonce,
  input  logic [L-1:0]   ad,
  input  logic [Y-1:0]   ct,
  input  logic [16:0]    rnd,
  output logic [2:0]     key_xsi,
  output logic [2:0]     nonce_xsi,
  output logic [2:0]     ad_xsi,
  output logic [2:0]     ct_xsi,
  output logic [6:0]     r_64,
  output logic           r_128,
  output logic           r_pt,
  output logic           core_start,
  input  logic           pt_xso,
  input  logic           tag_xso,
  input  logic           core_ready,
  output logic           busy,
  output logic           done,
  output logic [Y-1:0]   pt,
  output logic [127:0]   tag,
  output logic [15:0]    lat
`ifdef ASCON_CTRL_TIMEOUT_EN
  ,
  output logic           err
`endif
);

  localparam int MAX = (K > L) ? ((K > Y) ? K : Y) : ((L > Y) ? L : Y);
  localparam int CW  = $clog2(MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    DRAIN,
    READ,
    DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  i;
  logic [16:0]    rndQ;
  logic [3:0]     share0;   // {key, nonce, ad, ct} share-0 bits
  logic [CW-1:0]  loadIdx;
  logic [K-1:0]   keySh;
  logic [127:0]   nonceSh;
  logic [L-1:0]   adSh;
  logic [Y-1:0]   ctSh;
  logic [3:0]     nxtShare0;
  logic [15:0]    latInc;

`ifdef ASCON_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]  wcnt;
`endif

  // Share-0 bits are registered, so select the bit for the cycle after this one;
  // shifting past the vector width yields the required zero padding.
  always_comb begin
    loadIdx   = (state == LOAD) ? i + 1'b1 : '0;
    keySh     = key << loadIdx;
    nonceSh   = nonce << loadIdx;
    adSh      = ad << loadIdx;
    ctSh      = ct << loadIdx;
    nxtShare0 = {keySh[K-1], nonceSh[127], adSh[L-1], ctSh[Y-1]};
    latInc    = (lat == '1) ? lat : lat + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      i          <= '0;
      rndQ       <= '0;
      share0     <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pt         <= '0;
      tag        <= '0;
      lat        <= '0;
`ifdef ASCON_CTRL_TIMEOUT_EN
      err        <= 1'b0;
      wcnt       <= '0;
`endif
    end else begin
      rndQ   <= rnd;
      done   <= 1'b0;
      share0 <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            state  <= LOAD;
            i      <= '0;
            busy   <= 1'b1;
            share0 <= nxtShare0;
`ifdef ASCON_CTRL_TIMEOUT_EN
            err    <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (i == CW'(MAX - 1)) begin
            state      <= START;
            i          <= '0;
            core_start <= 1'b1;
            lat        <= '0;
          end else begin
            i      <= i + 1'b1;
            share0 <= nxtShare0;
          end
        end
        START: begin
          lat <= latInc;
          if (i == CW'(START_CYC - 1)) begin
            state      <= WAIT;
            i          <= '0;
            core_start <= 1'b0;
`ifdef ASCON_CTRL_TIMEOUT_EN
            wcnt       <= '0;
`endif
          end else begin
            i <= i + 1'b1;
          end
        end
        WAIT: begin
          if (core_ready) begin
            state <= DRAIN;
            i     <= '0;
          end else begin
            lat <= latInc;
`ifdef ASCON_CTRL_TIMEOUT_EN
            if (wcnt == TW'(TIMEOUT - 1)) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
`endif
          end
        end
        DRAIN: begin
          if (i == CW'(DRAIN_CYC - 1)) begin
            state <= READ;
            i     <= '0;
          end else begin
            i <= i + 1'b1;
          end
        end
        READ: begin
          for (int unsigned b = 0; b < Y; b++) begin
            if (32'(i) == b) pt[b] <= pt_xso;
          end
          for (int unsigned b = 0; b < 128; b++) begin
            if (32'(i) == b) tag[b] <= tag_xso;
          end
          if (i == CW'(MAX - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            i <= i + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign key_xsi   = {rndQ[7:6], share0[3]};
  assign nonce_xsi = {rndQ[1:0], share0[2]};
  assign ad_xsi    = {rndQ[5:4], share0[1]};
  assign ct_xsi    = {rndQ[3:2], share0[0]};
  assign r_64      = rndQ[14:8];
  assign r_pt      = rndQ[15];
  assign r_128     = rndQ[16];

endmodule

// File: tb/tb_ascon_serial_ctrl.sv
// Directed bench for ascon_serial_ctrl with an inline core stub (fixed ready timing, known pt/tag streams).
module tb_ascon_serial_ctrl;

  logic          clk = 1'b0;
  logic          rst, req;
  logic [127:0]  key, nonce;
  logic [39:0]   ad;
  logic [79:0]   ct;
  logic [16:0]   rnd;
  logic [2:0]    key_xsi, nonce_xsi, ad_xsi, ct_xsi;
  logic [6:0]    r_64;
  logic          r_128, r_pt, core_start;
  logic          pt_xso, tag_xso, core_ready;
  logic          busy, done;
  logic [79:0]   pt;
  logic [127:0]  tag;
  logic [15:0]   lat;
`ifdef ASCON_CTRL_TIMEOUT_EN
  logic          err;
`endif

  int checks = 0;
  int errors = 0;
  int doneCnt = 0;
  logic [16:0]   prevRnd;
  logic [79:0]   P1, P2;
  logic [127:0]  T1, T2;

  ascon_serial_ctrl #(
    .K(128), .L(40), .Y(80), .START_CYC(3), .DRAIN_CYC(2), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .key(key), .nonce(nonce), .ad(ad), .ct(ct), .rnd(rnd),
    .key_xsi(key_xsi), .nonce_xsi(nonce_xsi), .ad_xsi(ad_xsi), .ct_xsi(ct_xsi),
    .r_64(r_64), .r_128(r_128), .r_pt(r_pt), .core_start(core_start),
    .pt_xso(pt_xso), .tag_xso(tag_xso), .core_ready(core_ready),
    .busy(busy), .done(done), .pt(pt), .tag(tag), .lat(lat)
`ifdef ASCON_CTRL_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) doneCnt <= doneCnt + 1;

  wire [16:0] rndOut = {r_128, r_pt, r_64, key_xsi[2:1], ad_xsi[2:1], ct_xsi[2:1], nonce_xsi[2:1]};
  wire [3:0]  share0 = {key_xsi[0], nonce_xsi[0], ad_xsi[0], ct_xsi[0]};

  task automatic check(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string nm);
    check({nm, "_busy"}, 128'(busy), 128'(0));
    check({nm, "_done"}, 128'(done), 128'(0));
    check({nm, "_start"}, 128'(core_start), 128'(0));
    check({nm, "_pt"}, 128'(pt), 128'(0));
    check({nm, "_tag"}, tag, 128'(0));
    check({nm, "_lat"}, 128'(lat), 128'(0));
    check({nm, "_share0"}, 128'(share0), 128'(0));
    check({nm, "_rnd"}, 128'(rndOut), 128'(0));
  endtask

  // waitCyc < 0: stub never raises ready. abortAt >= 0: rst during that READ cycle.
  task automatic runTxn(input int waitCyc, input logic [79:0] p, input logic [127:0] t,
                        input int abortAt, input logic [15:0] expLat);
    logic [127:0] keySh, nonceSh;
    logic [39:0]  adSh;
    logic [79:0]  ctSh, pSh;
    logic         busyAll;
    int           d0;
    d0 = doneCnt;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 128; i++) begin
      keySh = key << i; nonceSh = nonce << i; adSh = ad << i; ctSh = ct << i;
      check("load_bits", 128'(share0), 128'({keySh[127], nonceSh[127], adSh[39], ctSh[79]}));
      check("load_rnd", 128'(rndOut), 128'(prevRnd));
      check("load_busy", 128'({busy, core_start}), 128'(2'b10));
      if (i == 0) check("load_c0_kat", 128'(share0), 128'(4'b0001));
      if (i == 2) check("load_c2_kat", 128'(share0), 128'(4'b1100));
      if (i == 40) check("load_ad_pad", 128'(ad_xsi[0]), 128'(0));
      if (i == 79) check("load_ct_last", 128'(ct_xsi[0]), 128'(1));
      if (i == 80) check("load_ct_pad", 128'(ct_xsi[0]), 128'(0));
      if (i == 127) check("load_last", 128'({key_xsi[0], nonce_xsi[0]}), 128'(2'b10));
`ifdef ASCON_CTRL_TIMEOUT_EN
      if (i == 0) check("err_cleared", 128'(err), 128'(0));
`endif
      rnd = 17'($urandom);
      prevRnd = rnd;
      req = (i == 10);
      @(negedge clk);
    end
    req = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("start_pulse", 128'({core_start, busy}), 128'(2'b11));
      check("start_share0", 128'(share0), 128'(0));
      if (s == 0) check("lat_clear", 128'(lat), 128'(0));
      if (s == 2 && waitCyc == 0) core_ready = 1'b1;
      @(negedge clk);
    end
    if (waitCyc < 0) begin
`ifdef ASCON_CTRL_TIMEOUT_EN
      for (int w = 0; w < 16; w++) begin
        check("to_wait", 128'({busy, done}), 128'(2'b10));
        @(negedge clk);
      end
      check("to_done", 128'({done, err}), 128'(2'b11));
      check("to_pt_hold", 128'(pt), 128'(p));
      check("to_tag_hold", tag, t);
      @(negedge clk);
      check("to_idle", 128'({busy, done, err}), 128'(3'b001));
`else
      busyAll = 1'b1;
      for (int w = 0; w < 1000; w++) begin
        busyAll = busyAll & busy & ~done;
        @(negedge clk);
      end
      check("wait_forever", 128'(busyAll), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("wait_rst_busy", 128'(busy), 128'(0));
`endif
      return;
    end
    for (int w = 0; w < waitCyc; w++) begin
      check("wait_lat", 128'(lat), 128'(3 + w));
      check("wait_start", 128'(core_start), 128'(0));
      req = (w == 1);
      @(negedge clk);
    end
    req = 1'b0;
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("drain", 128'({busy, done, core_start}), 128'(3'b100));
      @(negedge clk);
    end
    for (int r = 0; r < 128; r++) begin
      pSh = p >> r;
      pt_xso  = (r < 80) ? pSh[0] : 1'b1;
      tag_xso = t[r];
      if (r == abortAt) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("abort");
        return;
      end
      @(negedge clk);
    end
    check("done_pulse", 128'({done, busy}), 128'(2'b11));
    check("pt", 128'(pt), 128'(p));
    check("tag", tag, t);
    check("lat", 128'(lat), 128'(expLat));
    @(negedge clk);
    check("idle_after", 128'({done, busy}), 128'(2'b00));
    check("pt_hold", 128'(pt), 128'(p));
    check("done_count", 128'(doneCnt - d0), 128'(1));
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; core_ready = 1'b0; pt_xso = 1'b0; tag_xso = 1'b0;
    key   = 128'h2db083053e848cefa30007336c47a5a1;
    nonce = 128'h3f3607dbce3503ba84f5843d623de056;
    ad    = 40'h4153434f4e;
    ct    = 80'h87a59a2ea49b233259e3;
    P1 = 80'h0123456789abcdef0f1e;
    P2 = 80'hfedcba9876543210f0e1;
    T1 = 128'hdeadbeef0badf00dcafebabe12345678;
    T2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    rnd = 17'h1a5c3;
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_rnd", 128'(rndOut), 128'(17'h1a5c3));
    check("idle_share0", 128'(share0), 128'(0));
    prevRnd = rnd;

    runTxn(5, P1, T1, -1, 16'd8);
    runTxn(0, P2, T2, 10, 16'd0);
    prevRnd = rnd;
    runTxn(2, P2, T2, -1, 16'd5);
    runTxn(-1, P2, T2, -1, 16'd0);
    prevRnd = rnd;
    runTxn(0, P1, T1, -1, 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
